// File: rtl/ebpf_fetch_pkg.sv
// Shared types and constants for the eBPF instruction fetch stage.
// insn_t mirrors the 64-bit eBPF encoding so decode can reuse it directly.
package ebpf_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam int OPC_LSB = 0;
  localparam int DST_LSB = 8;
  localparam int SRC_LSB = 12;
  localparam int OFF_LSB = 16;
  localparam int IMM_LSB = 32;

  typedef struct packed {
    logic [31:0] imm;
    logic [15:0] offset;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [7:0]  opcode;
  } insn_t;

  function automatic insn_t split_insn(input logic [63:0] word);
    insn_t s;
    s.opcode = word[OPC_LSB +: 8];
    s.dst    = word[DST_LSB +: 4];
    s.src    = word[SRC_LSB +: 4];
    s.offset = word[OFF_LSB +: 16];
    s.imm    = word[IMM_LSB +: 32];
    return s;
  endfunction

endpackage

// File: rtl/ebpf_fetch_buffer.sv
// Small FIFO of decoded instructions plus their PCs; flush empties it in one cycle.
module ebpf_fetch_buffer
  import ebpf_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 12,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  insn_t            i_insn,
  input  logic [AW-1:0]    i_pc,
  input  logic             i_pop,
  output insn_t            o_insn,
  output logic [AW-1:0]    o_pc,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  insn_t            r_insn_mem [DEPTH];
  logic [AW-1:0]    r_pc_mem   [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_insn  = r_insn_mem[r_rd_ptr];
  assign o_pc    = r_pc_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_insn_mem[r_wr_ptr] <= i_insn;
      r_pc_mem[r_wr_ptr]   <= i_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ebpf_fetch_unit.sv
// eBPF fetch stage: issues reads to a 1-cycle synchronous imem and presents
// split instructions to decode, with redirect, halt and end-of-memory handling.
module ebpf_fetch_unit
  import ebpf_fetch_pkg::*;
#(
  parameter int IMEM_AW   = 12,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [IMEM_AW-1:0] i_start_pc,
  output logic               o_imem_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [63:0]        i_imem_rdata,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [7:0]         o_opcode,
  output logic [3:0]         o_dst,
  output logic [3:0]         o_src,
  output logic [15:0]        o_offset,
  output logic [31:0]        o_imm,
  output logic [IMEM_AW-1:0] o_pc_out,
  input  logic               i_redirect_valid,
  input  logic [IMEM_AW-1:0] i_redirect_pc,
  input  logic               i_halt_req,
  output logic               o_busy,
  output logic               o_fetch_exc,
  output fetch_state_t       o_state
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t       r_state;
  logic [IMEM_AW:0]   r_pc;          // extra MSB marks "ran past the top"
  logic               r_inflight;
  logic [IMEM_AW-1:0] r_inflight_pc;
  logic               r_fetch_exc;

  logic               w_in_fetch, w_halt, w_redirect, w_flush;
  logic               w_buf_empty, w_buf_full, w_bypass;
  logic               w_out_valid, w_pop, w_push, w_issue, w_drained, w_top;
  logic [CNT_W-1:0]   w_buf_count;
  logic [CNT_W:0]     w_occ;
  insn_t              w_buf_insn, w_rd_insn, w_head_insn;
  logic [IMEM_AW-1:0] w_buf_pc, w_head_pc;

  // start outranks halt, halt outranks redirect; all three kill the in-flight read.
  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_halt     = w_in_fetch && i_halt_req && !i_start;
  assign w_redirect = w_in_fetch && i_redirect_valid && !i_halt_req && !i_start;
  assign w_flush    = i_start || w_halt || w_redirect;
  assign w_top      = r_pc[IMEM_AW];

  // Handshake: an instruction transfers on a cycle with o_out_valid && i_out_ready;
  // while o_out_valid && !i_out_ready every output field holds its value.
  // An empty buffer lets returning read data bypass straight to the outputs.
  assign w_bypass    = w_buf_empty && r_inflight;
  assign w_out_valid = w_in_fetch && !w_flush && (!w_buf_empty || r_inflight);
  assign w_pop       = w_out_valid && i_out_ready;
  assign w_push      = r_inflight && !w_flush && !(w_bypass && w_pop);

  assign w_occ     = {1'b0, w_buf_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
  assign w_issue   = w_in_fetch && !w_flush && !w_top && !(w_buf_full && !w_pop) &&
                     (w_occ < (CNT_W + 1)'(BUF_DEPTH));
  assign w_drained = w_in_fetch && !w_flush && w_top && (w_occ == '0);

  assign w_rd_insn   = split_insn(i_imem_rdata);
  assign w_head_insn = w_buf_empty ? w_rd_insn : w_buf_insn;
  assign w_head_pc   = w_buf_empty ? r_inflight_pc : w_buf_pc;

  ebpf_fetch_buffer #(
    .DEPTH(BUF_DEPTH),
    .AW   (IMEM_AW)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(w_flush),
    .i_push (w_push),
    .i_insn (w_rd_insn),
    .i_pc   (r_inflight_pc),
    .i_pop  (w_pop && !w_buf_empty),
    .o_insn (w_buf_insn),
    .o_pc   (w_buf_pc),
    .o_full (w_buf_full),
    .o_empty(w_buf_empty),
    .o_count(w_buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fetch_exc   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc[IMEM_AW-1:0];
      if (i_start) begin
        r_state     <= ST_FETCH;
        r_pc        <= {1'b0, i_start_pc};
        r_fetch_exc <= 1'b0;
      end else if (w_halt) begin
        r_state <= ST_HALT;
      end else if (w_redirect) begin
        r_pc <= {1'b0, i_redirect_pc};
      end else if (w_drained) begin
        r_state     <= ST_HALT;
        r_fetch_exc <= 1'b1;
      end else if (w_issue) begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  assign o_imem_en   = w_issue;
  assign o_imem_addr = r_pc[IMEM_AW-1:0];
  assign o_out_valid = w_out_valid;
  assign o_opcode    = w_out_valid ? w_head_insn.opcode : '0;
  assign o_dst       = w_out_valid ? w_head_insn.dst    : '0;
  assign o_src       = w_out_valid ? w_head_insn.src    : '0;
  assign o_offset    = w_out_valid ? w_head_insn.offset : '0;
  assign o_imm       = w_out_valid ? w_head_insn.imm    : '0;
  assign o_pc_out    = w_out_valid ? w_head_pc          : '0;
  assign o_busy      = w_in_fetch;
  assign o_fetch_exc = r_fetch_exc;
  assign o_state     = r_state;

endmodule

// File: doc/ebpf_fetch_unit.md
Name: ebpf_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the eBPF control/decode unit.
- Reads 64-bit eBPF instructions from a synchronous instruction memory and splits them into opcode/dst/src/offset/imm.
- Presents them to decode over a valid/ready handshake.
- Handles start, branch redirect, halt on EXIT/exception, and out-of-range PC.

Parameters:
- IMEM_AW, 12, instruction-memory address width in 64-bit words; PC space is 0..2**IMEM_AW-1.
- BUF_DEPTH, 2, output buffer entries. Minimum 2, which covers the 1-cycle memory latency at full throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin fetching at start_pc
- start_pc  in  IMEM_AW  initial PC
- imem_en  out  1  read enable
- imem_addr  out  IMEM_AW  read address (word index)
- imem_rdata  in  64  read data, valid the cycle after imem_en
- out_valid  out  1  instruction available
- out_ready  in  1  decode accepts
- opcode  out  8  imem_rdata[7:0]
- dst  out  4  [11:8]
- src  out  4  [15:12]
- offset  out  16  [31:16]
- imm  out  32  [63:32]
- pc_out  out  IMEM_AW  PC of the presented instruction
- redirect_valid  in  1  branch taken
- redirect_pc  in  IMEM_AW  branch target, absolute word index
- halt_req  in  1  EXIT or exception from control unit (controlExc != NO_EXCEPTION)
- busy  out  1  state != IDLE/HALT
- fetch_exc  out  1  PC ran past the top of memory; sticky until start

Behaviour:
- Reset (async, rst_n=0) and every output then:
  - state=IDLE, pc=0, buffer empty, no read in flight.
  - imem_en=0, imem_addr=0, out_valid=0, field outputs 0, pc_out=0, busy=0, fetch_exc=0.
- States: IDLE, FETCH, HALT.
  - IDLE/HALT -> FETCH on start: pc<=start_pc, buffer flushed, fetch_exc<=0.
  - FETCH -> HALT on halt_req, or when an issued PC would exceed 2**IMEM_AW-1 (fetch_exc<=1).
- Issue rule (FETCH only): imem_en=1 when (buffered + in_flight) < BUF_DEPTH after this cycle's pop. imem_addr=pc; pc<=pc+1.
- Latency:
  - start at cycle T -> first imem_en at T+1 -> out_valid at T+2.
  - Sustained throughput 1 instruction/cycle while out_ready=1.
- Read return: the cycle after an un-killed issue, the data is pushed with its PC into the buffer.
- Output: head of buffer. Pop on out_valid&&out_ready. Outputs hold stable while out_valid&&!out_ready.
- Redirect (priority over issue and pop):
  - Flush the buffer and mark the in-flight read killed (its return is discarded). pc<=redirect_pc.
  - out_valid=0 in the redirect cycle; no handshake occurs then.
  - First target instruction is valid 2 cycles after redirect.
- Redirect and halt_req in the same cycle: halt wins.
- Halt: buffer flushed, in-flight read killed, out_valid=0, imem_en=0. Held in HALT until start.
- start while in FETCH: treated as redirect to start_pc, and clears fetch_exc.
- LDDW: no special handling. Both slots are fetched as ordinary consecutive words; pairing is checked downstream.
- Out of range: the instruction at the top address is still fetched and delivered. The next issue does not occur; fetch_exc=1 and state->HALT only once that last instruction has popped.
- start, redirect_pc, and start_pc are used as-is (no bounds check on targets).

Decomposition:
- Shared package ebpf_fetch_pkg:
  - fetch_state_t enum.
  - Instruction-field bit-position constants (OPC_LSB=0, DST_LSB=8, SRC_LSB=12, OFF_LSB=16, IMM_LSB=32).
  - Packed struct insn_t {imm, offset, src, dst, opcode}, reused by decode.
- One sub-module: ebpf_fetch_buffer, a small FIFO of {insn_t, pc} with a flush input. It has push/pop/full/empty/count and the same clk/rst_n.

Test Plan:
- Reset mid-fetch (rst_n low at cycle 5) -> all outputs 0 same cycle; after release, idle until start.
- start, start_pc=0x010, out_ready=1, imem word at 0x010 = 64'h0000002A_0000_01B7 -> out_valid at T+2 with opcode=0xB7, dst=1, src=0, offset=0, imm=0x2A, pc_out=0x010; then pc_out 0x011, 0x012 on consecutive cycles.
- out_ready=0 for 4 cycles -> imem_en drops after buffer full (2 entries), outputs stable; then out_ready=1 -> 0x010..0x013 delivered in order, no loss or duplication.
- redirect_valid with redirect_pc=0x040 while 0x012 is valid and a read is in flight -> 0x012/0x013 never handshake; next accepted pc_out=0x040, 2 cycles later.
- halt_req coincident with redirect_valid -> HALT, out_valid=0, imem_en=0; no further handshake until start.
- start_pc=2**IMEM_AW-2 -> two instructions delivered, then fetch_exc=1, busy=0, state HALT.
